// File: rtl/cbf_pkg.sv
// Shared definitions for the cbf output stage: counter sizing, sample type, stats width.
package cbf_pkg;

    localparam int CBF_WIDTH  = 24;
    localparam int DROP_CNT_W = 16;

    typedef logic signed [CBF_WIDTH-1:0] sample_t;

    // Width of a counter that spans 0..osr-1; never narrower than one bit.
    function automatic int cnt_w(input int osr);
        return (osr <= 1) ? 1 : $clog2(osr);
    endfunction

endpackage

// File: rtl/cbf_sync_fifo.sv
// Show-ahead synchronous FIFO: head entry is always presented from a register.
module cbf_sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
    logic [WIDTH-1:0] head_reg, head_next;
    logic             push_ok, pop_ok;
    logic [AW-1:0]    rd_idx_next;

    assign level   = wr_ptr_reg - rd_ptr_reg;
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop_ok  = pop && !empty;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push_ok = push && (!full || pop_ok);
    assign rd_idx_next = rd_ptr_reg[AW-1:0] + AW'(1);
    assign head    = head_reg;

    always_comb begin
        head_next = head_reg;
        if (pop_ok) begin
            if (level > (AW+1)'(1))
                head_next = mem[rd_idx_next];
            else if (push_ok)
                head_next = push_data;
        end else if (empty && push_ok) begin
            head_next = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            head_reg   <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            head_reg <= head_next;
        end
    end

endmodule

// File: rtl/cbf_out_decimator.sv
// Decimates the filter result stream by OSR, converts to two's complement and buffers it.
// Optional CBF_DEC_STATS_EN adds a saturating drop_count output.
module cbf_out_decimator
    import cbf_pkg::*;
#(
    parameter int OSR        = 12,
    parameter int WIDTH      = 24,
    parameter int PHASE      = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              in_data,
    input  logic                          in_valid,
    output logic [WIDTH-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
`ifdef CBF_DEC_STATS_EN
    output logic [DROP_CNT_W-1:0]         drop_count,
`endif
    output logic                          overflow
);

    localparam int CW = cnt_w(OSR);
    localparam logic [CW-1:0] PHASE_C = CW'(PHASE);
    localparam logic [CW-1:0] LAST_C  = CW'(OSR - 1);

    logic [CW-1:0]    cnt_reg;
    logic             keep, pop, fifo_full, fifo_empty, drop;
    logic             overflow_reg;
    logic [WIDTH-1:0] conv_data;

    assign keep      = in_valid && (cnt_reg == PHASE_C);
    assign conv_data = {~in_data[WIDTH-1], in_data[WIDTH-2:0]};
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign drop      = keep && fifo_full && !pop;
    assign overflow  = overflow_reg;

    // An idle cycle restarts the window so the next valid word is index 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_reg <= '0;
        else if (!in_valid)
            cnt_reg <= '0;
        else if (cnt_reg == LAST_C)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_reg + CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            overflow_reg <= 1'b0;
        else if (drop)
            overflow_reg <= 1'b1;
    end

`ifdef CBF_DEC_STATS_EN
    logic [DROP_CNT_W-1:0] drop_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            drop_cnt_reg <= '0;
        else if (drop && (drop_cnt_reg != {DROP_CNT_W{1'b1}}))
            drop_cnt_reg <= drop_cnt_reg + DROP_CNT_W'(1);
    end

    assign drop_count = drop_cnt_reg;
`endif

    cbf_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (keep),
        .push_data (conv_data),
        .pop       (pop),
        .head      (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

endmodule

// File: tb/tb_cbf_out_decimator.sv
// Directed bench for cbf_out_decimator at OSR=12, WIDTH=24, PHASE=0, FIFO_DEPTH=8.
module tb_cbf_out_decimator;
    import cbf_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic [23:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  fifo_level;
    logic        overflow;
`ifdef CBF_DEC_STATS_EN
    logic [15:0] drop_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cbf_out_decimator #(
        .OSR        (12),
        .WIDTH      (24),
        .PHASE      (0),
        .FIFO_DEPTH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
`ifdef CBF_DEC_STATS_EN
        .drop_count (drop_count),
`endif
        .overflow   (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({out_valid, fifo_level, overflow, out_data} !== {1'b0, 4'd0, 1'b0, 24'd0}) begin
            n_err++;
            $display("FAIL reset: valid=%0b level=%0d ovf=%0b data=%h, want 0/0/0/000000",
                     out_valid, fifo_level, overflow, out_data);
        end
`ifdef CBF_DEC_STATS_EN
        n_cmp++;
        if (drop_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_drop_count: got %0d want 0", drop_count);
        end
`endif
        rst = 1'b1;
        tick();
        $display("reset: released");
    endtask

    task automatic test_ramp();
        out_ready = 1'b1;
        for (int i = 0; i < 36; i++) begin
            in_data  = 24'h800000 + 24'(i);
            in_valid = 1'b1;
            tick();
            n_cmp++;
            if (i % 12 == 0) begin
                if (!(out_valid === 1'b1 && out_data === 24'(i) && fifo_level === 4'd1)) begin
                    n_err++;
                    $display("FAIL ramp_keep[%0d]: valid=%0b data=%h level=%0d, want 1/%h/1",
                             i, out_valid, out_data, fifo_level, 24'(i));
                end else
                    $display("ramp: idx %0d -> out %h", i, out_data);
            end else if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL ramp_idle[%0d]: valid=%0b want 0", i, out_valid);
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (overflow !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ramp_end: ovf=%0b valid=%0b want 0/0", overflow, out_valid);
        end
    endtask

    task automatic test_conversion();
        logic [23:0] vin [3];
        sample_t     vexp [3];
        vin[0] = 24'h000000; vexp[0] = -24'sd8388608;
        vin[1] = 24'hFFFFFF; vexp[1] = 24'sd8388607;
        vin[2] = 24'h800000; vexp[2] = 24'sd0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data  = vin[k];
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== vexp[k]) begin
                n_err++;
                $display("FAIL conv[%0d]: in=%h valid=%0b got %h want %h",
                         k, vin[k], out_valid, out_data, vexp[k]);
            end else
                $display("conv: in %h -> %0d", vin[k], $signed(out_data));
            tick();
        end
    endtask

    task automatic test_overflow_and_full_pushpop();
        out_ready = 1'b0;
        for (int i = 0; i < 108; i++) begin
            in_data  = 24'h800000 + 24'(i);
            in_valid = 1'b1;
            tick();
            if (i == 84) begin
                n_cmp++;
                if (fifo_level !== 4'd8 || overflow !== 1'b0) begin
                    n_err++;
                    $display("FAIL fill_8: level=%0d ovf=%0b want 8/0", fifo_level, overflow);
                end
            end
        end
        n_cmp++;
        if (fifo_level !== 4'd8 || overflow !== 1'b1 || out_data !== 24'd0) begin
            n_err++;
            $display("FAIL overflow: level=%0d ovf=%0b head=%h want 8/1/000000",
                     fifo_level, overflow, out_data);
        end else
            $display("overflow: level 8, sticky flag set");
`ifdef CBF_DEC_STATS_EN
        n_cmp++;
        if (drop_count !== 16'd1) begin
            n_err++;
            $display("FAIL drop_count: got %0d want 1", drop_count);
        end
`endif
        // Full FIFO: keep word 108 while popping the head on the same edge.
        in_data   = 24'h800000 + 24'd108;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (fifo_level !== 4'd8 || overflow !== 1'b1 || out_data !== 24'd12) begin
            n_err++;
            $display("FAIL full_pushpop: level=%0d ovf=%0b head=%h want 8/1/00000c",
                     fifo_level, overflow, out_data);
        end else
            $display("full_pushpop: level stays 8");
`ifdef CBF_DEC_STATS_EN
        n_cmp++;
        if (drop_count !== 16'd1) begin
            n_err++;
            $display("FAIL drop_count_pushpop: got %0d want 1", drop_count);
        end
`endif
        tick();
        n_cmp++;
        if (out_data !== 24'd12 || fifo_level !== 4'd8) begin
            n_err++;
            $display("FAIL hold_stable: head=%h level=%0d want 00000c/8", out_data, fifo_level);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [23:0] want;
            want = (k < 7) ? 24'(12 * (k + 1)) : 24'd108;
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== want) begin
                n_err++;
                $display("FAIL drain[%0d]: valid=%0b got %h want %h", k, out_valid, out_data, want);
            end else
                $display("drain: %0d -> %h", k, out_data);
            tick();
        end
        n_cmp++;
        if (out_valid !== 1'b0 || fifo_level !== 4'd0 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL drain_end: valid=%0b level=%0d ovf=%0b want 0/0/1",
                     out_valid, fifo_level, overflow);
        end
    endtask

    task automatic test_phase_restart();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data  = 24'h800000 + 24'(i);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        in_data  = 24'h800100;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 24'h000100) begin
            n_err++;
            $display("FAIL phase_restart: valid=%0b got %h want 000100", out_valid, out_data);
        end else
            $display("phase_restart: first word after reassert kept");
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            in_data  = 24'h800000 + 24'(k);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
        end
        n_cmp++;
        if (fifo_level !== 4'd4 || out_data !== 24'd1) begin
            n_err++;
            $display("FAIL queued4: level=%0d head=%h want 4/000001", fifo_level, out_data);
        end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || fifo_level !== 4'd0 || overflow !== 1'b0 || out_data !== 24'd0) begin
            n_err++;
            $display("FAIL async_reset: valid=%0b level=%0d ovf=%0b data=%h want 0/0/0/000000",
                     out_valid, fifo_level, overflow, out_data);
        end else
            $display("async_reset: cleared without clock edge");
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_conversion();
        test_overflow_and_full_pushpop();
        test_phase_restart();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
